sprite_color_mapper: RTL and testbench

Parametrised, pipelined successor to the single-tank colour mapper. Composites up to NUM_SPRITES rectangular sprites onto a solid background for each VGA pixel. Sprite images come from external synchronous frame ROMs, with one ROM per channel. The block adds transparency keying, fixed index priority, frame-synchronous position latching (no mid-frame tearing) and correct alignment to ROM read latency. It sits between the VGA controller / game-logic blocks and the VGA DAC outputs.

---
 rtl/sprite_color_mapper.sv | 159 +++++++++++++++
 tb/tb_sprite_color_mapper.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_color_mapper.sv
// Composites NUM_SPRITES rectangular ROM-backed sprites over a solid background,
// one pixel per clock with a fixed three-cycle latency from DrawX/DrawY to VGA_*.
module sprite_color_mapper #(
  parameter int              NUM_SPRITES = 4,
  parameter int              SPR_W       = 50,
  parameter int              SPR_H       = 50,
  parameter int              ADDR_W      = 12,
  parameter logic [23:0]     TRANSP_KEY  = 24'hFF00FF,
  parameter logic [23:0]     BG_COLOR    = 24'hFFFFFF
) (
  input  logic                            Clk,
  input  logic                            Reset_n,
  input  logic                            frame_start,
  input  logic                            pix_valid,
  input  logic [9:0]                      DrawX,
  input  logic [9:0]                      DrawY,
  input  logic [NUM_SPRITES*10-1:0]       sprX,
  input  logic [NUM_SPRITES*10-1:0]       sprY,
  input  logic [NUM_SPRITES-1:0]          spr_en,
  output logic [NUM_SPRITES*ADDR_W-1:0]   rom_addr,
  input  logic [NUM_SPRITES*24-1:0]       rom_data,
  output logic [7:0]                      VGA_R,
  output logic [7:0]                      VGA_G,
  output logic [7:0]                      VGA_B,
  output logic                            VGA_valid,
  output logic [$clog2(NUM_SPRITES):0]    hit_id
);

  localparam int             ID_W   = $clog2(NUM_SPRITES);
  localparam logic [ID_W:0]  BG_ID  = {1'b1, {ID_W{1'b0}}};
  localparam logic [10:0]    SPR_W11 = 11'(SPR_W);
  localparam logic [10:0]    SPR_H11 = 11'(SPR_H);
  localparam logic [21:0]    SPR_W22 = 22'(SPR_W);

  // Frame-synchronous shadow copies of the sprite positions and enables.
  logic [NUM_SPRITES*10-1:0] sx;
  logic [NUM_SPRITES*10-1:0] sy;
  logic [NUM_SPRITES-1:0]    sen;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx  <= '0;
      sy  <= '0;
      sen <= '0;
    end else if (frame_start) begin
      sx  <= sprX;
      sy  <= sprY;
      sen <= spr_en;
    end
  end

  // A pixel coinciding with frame_start must already see the new positions.
  logic [NUM_SPRITES*10-1:0] eff_x;
  logic [NUM_SPRITES*10-1:0] eff_y;
  logic [NUM_SPRITES-1:0]    eff_en;

  assign eff_x  = frame_start ? sprX   : sx;
  assign eff_y  = frame_start ? sprY   : sy;
  assign eff_en = frame_start ? spr_en : sen;

  // Stage 1: per-channel hit test and ROM address.
  logic [10:0]                    dx [NUM_SPRITES];
  logic [10:0]                    dy [NUM_SPRITES];
  logic [21:0]                    lin [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]         hit_c;
  logic [NUM_SPRITES*ADDR_W-1:0]  addr_c;

  always_comb begin
    hit_c  = '0;
    addr_c = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      dx[i]  = {1'b0, DrawX} - {1'b0, eff_x[i*10 +: 10]};
      dy[i]  = {1'b0, DrawY} - {1'b0, eff_y[i*10 +: 10]};
      lin[i] = {11'b0, dy[i]} * SPR_W22 + {11'b0, dx[i]};
      // A negative offset sets bit 10, so sprites never wrap around the screen.
      hit_c[i] = eff_en[i] & pix_valid &
                 ~dx[i][10] & (dx[i] < SPR_W11) &
                 ~dy[i][10] & (dy[i] < SPR_H11);
      addr_c[i*ADDR_W +: ADDR_W] = hit_c[i] ? lin[i][ADDR_W-1:0] : '0;
    end
  end

  logic [NUM_SPRITES-1:0] hit1;
  logic                   vld1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr <= '0;
      hit1     <= '0;
      vld1     <= 1'b0;
    end else begin
      rom_addr <= addr_c;
      hit1     <= hit_c;
      vld1     <= pix_valid;
    end
  end

  // Stage 2: hold hit flags one cycle so they line up with rom_data.
  logic [NUM_SPRITES-1:0] hit2;
  logic                   vld2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hit2 <= '0;
      vld2 <= 1'b0;
    end else begin
      hit2 <= hit1;
      vld2 <= vld1;
    end
  end

  // Stage 3: transparency keying and fixed priority (lowest index wins).
  logic [NUM_SPRITES-1:0] opaque;
  logic                   win_any;
  logic [ID_W-1:0]        win_idx;
  logic [23:0]            win_col;

  always_comb begin
    opaque  = '0;
    win_any = 1'b0;
    win_idx = '0;
    win_col = BG_COLOR;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      opaque[i] = hit2[i] & (rom_data[i*24 +: 24] != TRANSP_KEY);
    end
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_any = 1'b1;
        win_idx = ID_W'(i);
        win_col = rom_data[i*24 +: 24];
      end
    end
  end

  // VGA_valid qualifies VGA_R/G/B and hit_id in the same cycle; there is no
  // back-pressure, so every presented pixel emerges exactly three cycles later.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_valid <= 1'b0;
      hit_id    <= BG_ID;
    end else if (!vld2) begin
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
      VGA_valid <= 1'b0;
      hit_id    <= BG_ID;
    end else begin
      VGA_R     <= win_col[23:16];
      VGA_G     <= win_col[15:8];
      VGA_B     <= win_col[7:0];
      VGA_valid <= 1'b1;
      hit_id    <= win_any ? {1'b0, win_idx} : BG_ID;
    end
  end

endmodule

// File: tb/tb_sprite_color_mapper.sv
// Directed bench for sprite_color_mapper: the driver pushes hand-computed pixels
// into a queue, the monitor pops each one when its output cycle arrives.
module tb_sprite_color_mapper;

  localparam int NS = 4;
  localparam int AW = 12;
  localparam int EW = 60;  // {due[31:0], valid, rgb[23:0], id[2:0]}

  logic             Clk;
  logic             Reset_n;
  logic             frame_start;
  logic             pix_valid;
  logic [9:0]       DrawX;
  logic [9:0]       DrawY;
  logic [NS*10-1:0] sprX;
  logic [NS*10-1:0] sprY;
  logic [NS-1:0]    spr_en;
  logic [NS*AW-1:0] rom_addr;
  logic [NS*24-1:0] rom_data;
  logic [7:0]       VGA_R;
  logic [7:0]       VGA_G;
  logic [7:0]       VGA_B;
  logic             VGA_valid;
  logic [2:0]       hit_id;

  logic [NS-1:0]    key_force;
  logic [EW-1:0]    exp_q[$];
  int               cyc;
  int               checks;
  int               errors;

  sprite_color_mapper #(
    .NUM_SPRITES(NS), .SPR_W(50), .SPR_H(50), .ADDR_W(AW),
    .TRANSP_KEY(24'hFF00FF), .BG_COLOR(24'hFFFFFF)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .sprX(sprX), .sprY(sprY), .spr_en(spr_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_valid(VGA_valid), .hit_id(hit_id)
  );

  // Clock / reset-independent cycle counter
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous ROM model: channel i returns {i+1, 00, addr}, or the key when forced.
  always @(posedge Clk) begin
    for (int i = 0; i < NS; i++)
      rom_data[i*24 +: 24] <= key_force[i] ? 24'hFF00FF
                                           : {4'(i + 1), 8'h00, rom_addr[i*AW +: AW]};
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the head entry in the cycle its output is due.
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      if (int'(e[59:28]) == cyc) begin
        void'(exp_q.pop_front());
        chk($sformatf("pixel@%0d", cyc), 64'({VGA_valid, VGA_R, VGA_G, VGA_B, hit_id}),
            64'(e[27:0]));
      end else if (int'(e[59:28]) < cyc) begin
        void'(exp_q.pop_front());
        chk($sformatf("missed@%0d", int'(e[59:28])), 64'(cyc), 64'(e[59:28]));
      end
    end
  end

  // Driver: one pixel per negedge; output is due after the third following posedge.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic pv,
                     input logic fs, input logic [23:0] rgb, input logic [2:0] id);
    @(negedge Clk);
    DrawX = x; DrawY = y; pix_valid = pv; frame_start = fs;
    exp_q.push_back({32'(cyc + 3), pv, pv ? rgb : 24'h0, pv ? id : 3'd4});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) pix(10'd0, 10'd0, 1'b0, 1'b0, 24'h0, 3'd4);
  endtask

  task automatic set_spr(input int ch, input logic [9:0] x, input logic [9:0] y);
    sprX[ch*10 +: 10] = x;
    sprY[ch*10 +: 10] = y;
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_pix"}, 64'({VGA_valid, VGA_R, VGA_G, VGA_B, hit_id}), 64'({1'b0, 24'h0, 3'd4}));
    chk({name, "_addr"}, 64'(rom_addr), 64'(0));
  endtask

  initial begin
    checks = 0; errors = 0;
    Reset_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    DrawX = '0; DrawY = '0; sprX = '0; sprY = '0; spr_en = '0; key_force = '0;
    repeat (3) @(negedge Clk);
    chk_reset_outputs("reset");
    Reset_n = 1'b1;

    // Sprites disabled: every visible pixel is background, blanking follows pix_valid.
    pix(10'd0, 10'd0, 1'b0, 1'b1, 24'h0, 3'd4);
    for (int x = 0; x < 12; x++)
      pix(10'(x), 10'd10, (x % 3) != 0, 1'b0, 24'hFFFFFF, 3'd4);
    idle(3);

    // Sprite 0 at (100,200): colour encodes the ROM address.
    set_spr(0, 10'd100, 10'd200); spr_en = 4'b0001;
    pix(10'd0, 10'd0, 1'b0, 1'b1, 24'h0, 3'd4);
    pix(10'd100, 10'd200, 1'b1, 1'b0, 24'h100000, 3'd0);
    pix(10'd149, 10'd249, 1'b1, 1'b0, 24'h1009C3, 3'd0);
    pix(10'd150, 10'd200, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd99,  10'd200, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd100, 10'd250, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd100, 10'd199, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd120, 10'd210, 1'b1, 1'b0, 24'h100208, 3'd0);
    idle(3);

    // Overlap of channels 0 and 1, with transparency keying.
    set_spr(0, 10'd300, 10'd100); set_spr(1, 10'd300, 10'd100); spr_en = 4'b0011;
    pix(10'd0, 10'd0, 1'b0, 1'b1, 24'h0, 3'd4);
    pix(10'd310, 10'd110, 1'b1, 1'b0, 24'h1001FE, 3'd0);
    idle(3);
    key_force = 4'b0001;
    pix(10'd310, 10'd110, 1'b1, 1'b0, 24'h2001FE, 3'd1);
    idle(3);
    key_force = 4'b0011;
    pix(10'd310, 10'd110, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    idle(3);
    key_force = 4'b0000;

    // Mid-frame move is ignored until frame_start, which applies to its own pixel.
    set_spr(0, 10'd400, 10'd100);
    pix(10'd310, 10'd110, 1'b1, 1'b0, 24'h1001FE, 3'd0);
    pix(10'd410, 10'd110, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd410, 10'd110, 1'b1, 1'b1, 24'h1001FE, 3'd0);
    pix(10'd310, 10'd110, 1'b1, 1'b0, 24'h2001FE, 3'd1);
    idle(3);

    // Right/bottom clipping, no wrap-around.
    set_spr(0, 10'd1000, 10'd0); spr_en = 4'b0001;
    pix(10'd0, 10'd0, 1'b0, 1'b1, 24'h0, 3'd4);
    pix(10'd1000, 10'd5, 1'b1, 1'b0, 24'h1000FA, 3'd0);
    pix(10'd1023, 10'd5, 1'b1, 1'b0, 24'h100111, 3'd0);
    pix(10'd0,    10'd5, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd25,   10'd5, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd1010, 10'd49, 1'b1, 1'b0, 24'h10099C, 3'd0);
    pix(10'd1010, 10'd50, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    idle(3);

    // Reset during an active line: in-flight pixels are dropped.
    pix(10'd1000, 10'd5, 1'b1, 1'b0, 24'h1000FA, 3'd0);
    pix(10'd1001, 10'd5, 1'b1, 1'b0, 24'h1000FB, 3'd0);
    pix(10'd1002, 10'd5, 1'b1, 1'b0, 24'h1000FC, 3'd0);
    #2;
    Reset_n = 1'b0; pix_valid = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    pix(10'd1000, 10'd5, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd5,    10'd5, 1'b1, 1'b0, 24'hFFFFFF, 3'd4);
    pix(10'd0, 10'd0, 1'b0, 1'b1, 24'h0, 3'd4);
    pix(10'd1000, 10'd5, 1'b1, 1'b0, 24'h1000FA, 3'd0);
    idle(4);

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge Clk);
    chk("drain", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
